// File: rtl/sb_pkg.sv
// Shared constants and helpers for the parametrised switch box.
// Holds select-width sizing, side numbering and the track permutation rule.
package sb_pkg;

    localparam int CFG_WORD_W = 32;

    localparam int SIDE_0 = 0;
    localparam int SIDE_1 = 1;
    localparam int SIDE_2 = 2;
    localparam int SIDE_3 = 3;
    localparam int NUM_SIDES = SIDE_3 + 1;

    // Each output can take one track from each of the three other sides.
    localparam int NUM_TRACK_SRC = 3;

    function automatic int sel_width(int num_pe);
        return $clog2(NUM_TRACK_SRC + num_pe);
    endfunction

    // Track on source side j feeding output track t of side s.
    // A side never sources itself; returning t keeps the function total.
    function automatic int src_track(int s, int t, int j, int n);
        if (j == s)
            return t;
        return (t + j + n - 1) % n;
    endfunction

endpackage

// File: rtl/sb_out_mux.sv
// One switch-box output: (3+NUM_PE):1 mux, WIRE_WIDTH bits wide.
// Ports: sel, track_in (3 side candidates), pe_in, out (zero on unused sel).
module sb_out_mux
    import sb_pkg::*;
#(
    parameter int WIRE_WIDTH = 1,
    parameter int NUM_PE = 1,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]                    sel,
    input  logic [NUM_TRACK_SRC*WIRE_WIDTH-1:0] track_in,
    input  logic [NUM_PE*WIRE_WIDTH-1:0]        pe_in,
    output logic [WIRE_WIDTH-1:0]               out
);

    always_comb begin
        out = '0;
        for (int k = 0; k < NUM_TRACK_SRC; k++)
            if (sel == SEL_W'(k))
                out = track_in[k*WIRE_WIDTH +: WIRE_WIDTH];
        for (int p = 0; p < NUM_PE; p++)
            if (sel == SEL_W'(NUM_TRACK_SRC + p))
                out = pe_in[p*WIRE_WIDTH +: WIRE_WIDTH];
    end

endmodule

// File: rtl/sb_param_switch_box.sv
// Double-buffered 4-side switch box: addressed shadow config, atomic commit.
// Ports: clk, reset (async high), in_wires, pe_outputs, out_wires,
// config_addr/data/en/commit, config_rd_data, config_pending.
// SB_OUT_REG_EN: register out_wires (1-cycle latency, async reset to 0).
module sb_param_switch_box
    import sb_pkg::*;
#(
    parameter int NUM_TRACKS = 4,
    parameter int WIRE_WIDTH = 1,
    parameter int NUM_PE = 1,
    localparam int SEL_W = sel_width(NUM_PE),
    localparam int NUM_OUT = NUM_SIDES * NUM_TRACKS,
    localparam int CFG_BITS = NUM_OUT * SEL_W,
    localparam int NUM_WORDS = (CFG_BITS + CFG_WORD_W - 1) / CFG_WORD_W,
    localparam int CFG_AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int BUS_W = NUM_OUT * WIRE_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BUS_W-1:0]             in_wires,
    input  logic [NUM_PE*WIRE_WIDTH-1:0] pe_outputs,
    output logic [BUS_W-1:0]             out_wires,
    input  logic [CFG_AW-1:0]            config_addr,
    input  logic [CFG_WORD_W-1:0]        config_data,
    input  logic                         config_en,
    input  logic                         config_commit,
    output logic [CFG_WORD_W-1:0]        config_rd_data,
    output logic                         config_pending
);

    localparam int LAST_BITS = CFG_BITS - (NUM_WORDS - 1) * CFG_WORD_W;
    localparam logic [CFG_WORD_W-1:0] LAST_MASK =
        (LAST_BITS >= CFG_WORD_W) ? '1 :
        ((CFG_WORD_W'(1) << LAST_BITS) - CFG_WORD_W'(1));

    logic [CFG_WORD_W-1:0] shadow [NUM_WORDS];
    logic [CFG_BITS-1:0]   shadow_bits;
    logic [CFG_BITS-1:0]   active;
    logic [NUM_WORDS-1:0]  wr_sel;
    logic                  wr_any;
    logic [CFG_WORD_W-1:0] rd_word;
    logic [BUS_W-1:0]      out_comb;

    always_comb begin
        wr_sel  = '0;
        rd_word = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (config_addr == CFG_AW'(w)) begin
                wr_sel[w] = config_en;
                rd_word   = shadow[w];
            end
        end
        wr_any = |wr_sel;
    end

    always_comb begin
        shadow_bits = '0;
        for (int b = 0; b < CFG_BITS; b++)
            shadow_bits[b] = shadow[b / CFG_WORD_W][b % CFG_WORD_W];
    end

    // Commit samples the pre-edge shadow, so a same-cycle write
    // stays pending for the next commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WORDS; w++)
                shadow[w] <= '0;
            active         <= '0;
            config_pending <= 1'b0;
            config_rd_data <= '0;
        end else begin
            for (int w = 0; w < NUM_WORDS; w++)
                if (wr_sel[w])
                    shadow[w] <= config_data &
                        ((w == NUM_WORDS - 1) ? LAST_MASK : '1);
            if (config_commit)
                active <= shadow_bits;
            if (wr_any)
                config_pending <= 1'b1;
            else if (config_commit)
                config_pending <= 1'b0;
            config_rd_data <= rd_word;
        end
    end

    for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
        for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
            localparam int O = s * NUM_TRACKS + t;
            logic [NUM_TRACK_SRC*WIRE_WIDTH-1:0] cand;
            for (genvar k = 0; k < NUM_TRACK_SRC; k++) begin : g_k
                localparam int J = (s + 1 + k) % NUM_SIDES;
                localparam int TR = src_track(s, t, J, NUM_TRACKS);
                assign cand[k*WIRE_WIDTH +: WIRE_WIDTH] =
                    in_wires[(J*NUM_TRACKS + TR)*WIRE_WIDTH +: WIRE_WIDTH];
            end
            sb_out_mux #(
                .WIRE_WIDTH(WIRE_WIDTH),
                .NUM_PE    (NUM_PE),
                .SEL_W     (SEL_W)
            ) u_mux (
                .sel     (active[O*SEL_W +: SEL_W]),
                .track_in(cand),
                .pe_in   (pe_outputs),
                .out     (out_comb[O*WIRE_WIDTH +: WIRE_WIDTH])
            );
        end
    end

`ifdef SB_OUT_REG_EN
    logic [BUS_W-1:0] out_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_q <= '0;
        else
            out_q <= out_comb;
    end
    assign out_wires = out_q;
`else
    assign out_wires = out_comb;
`endif

endmodule

// File: tb/tb_sb_param_switch_box.sv
// Self-checking bench for sb_param_switch_box (three parameter sets).
// Table vectors, directed corner sequences and a randomized model run.
module tb_sb_param_switch_box;

`ifdef SB_OUT_REG_EN
    localparam bit OREG = 1'b1;
`else
    localparam bit OREG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // A: NUM_TRACKS=4, WIRE_WIDTH=1, NUM_PE=1 (1 word)
    logic [15:0] a_in, a_out;
    logic        a_pe, a_addr, a_en, a_commit, a_pend;
    logic [31:0] a_data, a_rd;
    // B: NUM_TRACKS=8, WIRE_WIDTH=2, NUM_PE=2 (3 words)
    logic [63:0] b_in, b_out;
    logic [3:0]  b_pe;
    logic [1:0]  b_addr;
    logic        b_en, b_commit, b_pend;
    logic [31:0] b_data, b_rd;
    // C: NUM_TRACKS=3, WIRE_WIDTH=1, NUM_PE=3 (36 bits, 2 words)
    logic [11:0] c_in, c_out;
    logic [2:0]  c_pe;
    logic        c_addr, c_en, c_commit, c_pend;
    logic [31:0] c_data, c_rd;

    sb_param_switch_box #(.NUM_TRACKS(4), .WIRE_WIDTH(1), .NUM_PE(1)) u_a (
        .clk(clk), .reset(reset), .in_wires(a_in), .pe_outputs(a_pe),
        .out_wires(a_out), .config_addr(a_addr), .config_data(a_data),
        .config_en(a_en), .config_commit(a_commit),
        .config_rd_data(a_rd), .config_pending(a_pend));

    sb_param_switch_box #(.NUM_TRACKS(8), .WIRE_WIDTH(2), .NUM_PE(2)) u_b (
        .clk(clk), .reset(reset), .in_wires(b_in), .pe_outputs(b_pe),
        .out_wires(b_out), .config_addr(b_addr), .config_data(b_data),
        .config_en(b_en), .config_commit(b_commit),
        .config_rd_data(b_rd), .config_pending(b_pend));

    sb_param_switch_box #(.NUM_TRACKS(3), .WIRE_WIDTH(1), .NUM_PE(3)) u_c (
        .clk(clk), .reset(reset), .in_wires(c_in), .pe_outputs(c_pe),
        .out_wires(c_out), .config_addr(c_addr), .config_data(c_data),
        .config_en(c_en), .config_commit(c_commit),
        .config_rd_data(c_rd), .config_pending(c_pend));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Routing straight from the written rules: field per output, then
    // either a rotated track from another side, a PE output, or zero.
    function automatic bit [255:0] ref_route(int nt, int ww, int np, int selw,
        bit [255:0] act, bit [255:0] inw, bit [255:0] pe);
        bit [255:0] res = '0;
        bit [255:0] wmask = (256'd1 << ww) - 256'd1;
        bit [255:0] v;
        int o, f, j, tr;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < nt; t++) begin
                o = s * nt + t;
                f = int'(act >> (o * selw)) & ((1 << selw) - 1);
                if (f < 3) begin
                    j  = (s + 1 + f) % 4;
                    tr = (t + j + nt - 1) % nt;
                    v  = (inw >> ((j * nt + tr) * ww)) & wmask;
                end else if (f < 3 + np) begin
                    v = (pe >> ((f - 3) * ww)) & wmask;
                end else begin
                    v = '0;
                end
                res |= v << (o * ww);
            end
        end
        return res;
    endfunction

    task automatic a_cycle(input logic en, input logic addr,
                           input logic [31:0] data, input logic commit);
        a_en = en; a_addr = addr; a_data = data; a_commit = commit;
        tick();
        a_en = 1'b0; a_commit = 1'b0;
    endtask

    task automatic c_cycle(input logic en, input logic addr,
                           input logic [31:0] data, input logic commit);
        c_en = en; c_addr = addr; c_data = data; c_commit = commit;
        tick();
        c_en = 1'b0; c_commit = 1'b0;
    endtask

    typedef struct {
        logic [31:0] cfg;
        logic [15:0] in_w;
        logic        pe;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    bit [31:0]  m_sh[3];
    bit [95:0]  m_act, old_act;
    bit         m_pend;
    bit [31:0]  rd_exp, cw;
    logic [31:0] cur_cfg;
    int          addr_i;
    bit          en_i, cm_i;

    initial begin
        vecs[0] = '{32'h0000_0000, 16'hA5C3, 1'b0, 16'h6AAC};
        vecs[1] = '{32'h0000_0000, 16'h0001, 1'b1, 16'h2000};
        vecs[2] = '{32'h0000_0000, 16'hFFFF, 1'b0, 16'hFFFF};
        vecs[3] = '{32'h5555_5555, 16'hA5C3, 1'b0, 16'hC6AA};
        vecs[4] = '{32'h5555_5555, 16'h0001, 1'b0, 16'h0200};
        vecs[5] = '{32'hAAAA_AAAA, 16'hA5C3, 1'b1, 16'hAC6A};
        vecs[6] = '{32'hAAAA_AAAA, 16'h0001, 1'b0, 16'h0020};
        vecs[7] = '{32'hFFFF_FFFF, 16'h1234, 1'b1, 16'hFFFF};
        vecs[8] = '{32'hFFFF_FFFF, 16'hFFFF, 1'b0, 16'h0000};
        vecs[9] = '{32'h0000_0001, 16'h0200, 1'b0, 16'h0011};

        reset = 1'b1;
        a_in = 16'hA5C3; a_pe = 1'b0; a_addr = 1'b0; a_data = '0;
        a_en = 1'b0; a_commit = 1'b0;
        b_in = '0; b_pe = '0; b_addr = '0; b_data = '0;
        b_en = 1'b0; b_commit = 1'b0;
        c_in = '0; c_pe = '0; c_addr = 1'b0; c_data = '0;
        c_en = 1'b0; c_commit = 1'b0;

        // Reset defaults
        #12;
        chk("rst_pend", 256'(a_pend), 256'(1'b0));
        chk("rst_rd", 256'(a_rd), 256'(32'h0));
        chk("rst_out", 256'(a_out), OREG ? 256'(16'h0) : 256'(16'h6AAC));
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("k0_route", 256'(a_out), 256'(16'h6AAC));

        // Shadow isolation
        a_cycle(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        chk("iso_pend", 256'(a_pend), 256'(1'b1));
        chk("iso_route", 256'(a_out), 256'(16'h6AAC));
        tick();
        chk("iso_rd", 256'(a_rd), 256'(32'hFFFF_FFFF));
        a_pe = 1'b1;
        a_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("commit_pend", 256'(a_pend), 256'(1'b0));
        tick();
        chk("commit_pe1", 256'(a_out), 256'(16'hFFFF));
        a_pe = 1'b0;
        tick();
        chk("commit_pe0", 256'(a_out), 256'(16'h0000));

        // Same-cycle write and commit
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        a_in = 16'h0200;
        tick();
        a_cycle(1'b1, 1'b0, 32'h0000_0001, 1'b1);
        chk("wc_pend", 256'(a_pend), 256'(1'b1));
        tick();
        chk("wc_route", 256'(a_out), 256'(16'h0010));
        a_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wc2_pend", 256'(a_pend), 256'(1'b0));
        tick();
        chk("wc2_route", 256'(a_out), 256'(16'h0011));

        // Out-of-range address
        a_cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("oor_pend", 256'(a_pend), 256'(1'b0));
        tick();
        chk("oor_rd", 256'(a_rd), 256'(32'h0));
        a_addr = 1'b0;
        tick();
        chk("oor_keep", 256'(a_rd), 256'(32'h1));

        // Table vectors
        cur_cfg = 32'h1;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].cfg !== cur_cfg) begin
                a_cycle(1'b1, 1'b0, vecs[i].cfg, 1'b0);
                a_cycle(1'b0, 1'b0, 32'h0, 1'b1);
                cur_cfg = vecs[i].cfg;
            end
            a_in = vecs[i].in_w;
            a_pe = vecs[i].pe;
            tick();
            chk($sformatf("vec%0d", i), 256'(a_out), 256'(vecs[i].exp));
        end

        // Asynchronous reset between edges
        a_cycle(1'b1, 1'b0, 32'h5555_5555, 1'b0);
        chk("pre_arst_pend", 256'(a_pend), 256'(1'b1));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_pend", 256'(a_pend), 256'(1'b0));
        chk("arst_rd", 256'(a_rd), 256'(32'h0));
        chk("arst_out", 256'(a_out), OREG ? 256'(16'h0) : 256'(16'h0010));
        @(negedge clk);
        reset = 1'b0;
        tick();

        // C: last-word masking, odd track count, PE and zero selects
        c_in = 12'(($urandom));
        c_pe = 3'($urandom);
        c_cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tick();
        chk("c_mask_rd", 256'(c_rd), 256'(32'h0000_000F));
        chk("c_pend", 256'(c_pend), 256'(1'b1));
        c_cycle(1'b0, 1'b1, 32'h0, 1'b1);
        tick();
        chk("c_route1", 256'(c_out), ref_route(3, 1, 3, 3,
            256'h0000_000F_0000_0000, 256'(c_in), 256'(c_pe)));
        for (int i = 0; i < 4; i++) begin
            cw = $urandom;
            c_in = 12'($urandom);
            c_pe = 3'($urandom);
            c_cycle(1'b1, 1'b0, cw, 1'b0);
            c_cycle(1'b0, 1'b0, 32'h0, 1'b1);
            tick();
            chk($sformatf("c_rand%0d", i), 256'(c_out),
                ref_route(3, 1, 3, 3, {224'h0000_000F, cw},
                          256'(c_in), 256'(c_pe)));
        end

        // B: ignored address 3, then randomized run against the model
        b_en = 1'b1; b_addr = 2'd3; b_data = 32'hCAFE_F00D;
        tick();
        b_en = 1'b0;
        chk("b_oor_pend", 256'(b_pend), 256'(1'b0));
        tick();
        chk("b_oor_rd", 256'(b_rd), 256'(32'h0));

        m_sh[0] = '0; m_sh[1] = '0; m_sh[2] = '0;
        m_act = '0; m_pend = 1'b0;
        for (int i = 0; i < 300; i++) begin
            en_i   = ($urandom_range(0, 1) == 1);
            cm_i   = ($urandom_range(0, 3) == 0);
            addr_i = $urandom_range(0, 3);
            b_en = en_i; b_commit = cm_i; b_addr = 2'(addr_i);
            b_data = $urandom;
            b_in = {$urandom, $urandom};
            b_pe = 4'($urandom);
            rd_exp  = (addr_i < 3) ? m_sh[addr_i] : 32'h0;
            old_act = m_act;
            tick();
            if (cm_i)
                m_act = {m_sh[2], m_sh[1], m_sh[0]};
            if (en_i && addr_i < 3)
                m_sh[addr_i] = b_data;
            if (en_i && addr_i < 3)
                m_pend = 1'b1;
            else if (cm_i)
                m_pend = 1'b0;
            chk("b_rd", 256'(b_rd), 256'(rd_exp));
            chk("b_pend", 256'(b_pend), 256'(m_pend));
            chk("b_out", 256'(b_out), ref_route(8, 2, 2, 3,
                OREG ? 256'(old_act) : 256'(m_act),
                256'(b_in), 256'(b_pe)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
